// File: rtl/adder_share_ctrl.sv
// Round-robin front end that time-shares one 16-bit ripple-carry adder among NUM_REQ requesters.
// Each 32-bit add runs as a low pass then a high pass, and the result is returned with its id.
module adder_share_ctrl #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    input  logic [NUM_REQ-1:0]   req_cin,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [32:0]          rsp_sum,
    output logic                 rsp_ovf,
    output logic                 busy,
    output logic [15:0]          op_count
);

    typedef enum logic [1:0] {StIdle, StLo, StHi, StResp} state_e;

    state_e          state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q;
    logic [31:0]     a_q, b_q;
    logic            cin_q;
    logic [ID_W-1:0] id_q;
    logic [15:0]     sum_lo_q;
    logic            c_mid_q;
    logic [32:0]     rsp_sum_q;
    logic            rsp_ovf_q;
    logic [ID_W-1:0] rsp_id_q;
    logic [15:0]     op_count_q;

    logic            gnt_found;
    logic [ID_W-1:0] gnt_id;
    int unsigned     idx;
    logic [31:0]     sel_a, sel_b;
    logic            sel_cin;
    logic            accept;

    logic [15:0]     add_a, add_b, add_sum;
    logic            add_ci, add_co, carry;

    // Search begins just after the last granted requester, so it ends up lowest priority.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        idx       = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = 32'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!gnt_found && req_valid[ID_W'(idx)]) begin
                gnt_found = 1'b1;
                gnt_id    = ID_W'(idx);
            end
        end
    end

    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        sel_cin = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == gnt_id) begin
                sel_a   = req_a[32*i +: 32];
                sel_b   = req_b[32*i +: 32];
                sel_cin = req_cin[i];
            end
        end
    end

    assign accept = (state_q == StIdle) && gnt_found;

    // The single shared adder: operand mux followed by a 16-bit ripple chain.
    always_comb begin
        add_a  = a_q[15:0];
        add_b  = b_q[15:0];
        add_ci = cin_q;
        if (state_q == StHi) begin
            add_a  = a_q[31:16];
            add_b  = b_q[31:16];
            add_ci = c_mid_q;
        end
        add_sum = '0;
        carry   = add_ci;
        for (int i = 0; i < 16; i++) begin
            add_sum[i] = add_a[i] ^ add_b[i] ^ carry;
            carry      = (add_a[i] & add_b[i]) | (carry & (add_a[i] ^ add_b[i]));
        end
        add_co = carry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (gnt_found) state_d = StLo;
            StLo:    state_d = StHi;
            StHi:    state_d = StResp;
            StResp:  if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // req_ready is gated by rst_n so it reads zero while reset is held.
    always_comb begin
        req_ready = '0;
        if (state_q == StIdle && rst_n && gnt_found) req_ready = NUM_REQ'(1) << gnt_id;
        rsp_valid = (state_q == StResp);
        busy      = (state_q != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q   <= ID_W'(NUM_REQ - 1);
            a_q        <= '0;
            b_q        <= '0;
            cin_q      <= 1'b0;
            id_q       <= '0;
            sum_lo_q   <= '0;
            c_mid_q    <= 1'b0;
            rsp_sum_q  <= '0;
            rsp_ovf_q  <= 1'b0;
            rsp_id_q   <= '0;
            op_count_q <= '0;
        end else begin
            if (accept) begin
                a_q      <= sel_a;
                b_q      <= sel_b;
                cin_q    <= sel_cin;
                id_q     <= gnt_id;
                rr_ptr_q <= gnt_id;
            end
            if (state_q == StLo) begin
                sum_lo_q <= add_sum;
                c_mid_q  <= add_co;
            end
            // Result registers load only here, so they hold outside RESP until the next op.
            if (state_q == StHi) begin
                rsp_sum_q <= {add_co, add_sum, sum_lo_q};
                rsp_ovf_q <= (a_q[31] == b_q[31]) && (add_sum[15] != a_q[31]);
                rsp_id_q  <= id_q;
            end
            if (state_q == StResp && rsp_ready) op_count_q <= op_count_q + 16'd1;
        end
    end

    assign rsp_sum  = rsp_sum_q;
    assign rsp_ovf  = rsp_ovf_q;
    assign rsp_id   = rsp_id_q;
    assign op_count = op_count_q;

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Directed bench for adder_share_ctrl: carry chaining, overflow, round-robin order,
// backpressure, mid-operation reset and response counting.
module tb_adder_share_ctrl;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned ID_W    = 2;

    logic                   clk;
    logic                   rst_n;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*32-1:0]  req_a;
    logic [NUM_REQ*32-1:0]  req_b;
    logic [NUM_REQ-1:0]     req_cin;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic [32:0]            rsp_sum;
    logic                   rsp_ovf;
    logic                   busy;
    logic [15:0]            op_count;

    int          vectors;
    int          miscompares;
    logic [15:0] exp_cnt;
    logic [32:0] exp_sum [NUM_REQ];
    logic        exp_ovf [NUM_REQ];

    adder_share_ctrl #(
        .NUM_REQ(NUM_REQ),
        .ID_W   (ID_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .req_cin  (req_cin),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id   (rsp_id),
        .rsp_sum  (rsp_sum),
        .rsp_ovf  (rsp_ovf),
        .busy     (busy),
        .op_count (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic c, input logic [32:0] s, input logic o);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_cin[i]        = c;
        exp_sum[i]        = s;
        exp_ovf[i]        = o;
    endtask

    // Starts in IDLE; expects requester id to be granted, stalls the response for hold cycles.
    task automatic run_op(input int id, input int hold);
        rsp_ready = (hold == 0);
        #1;
        check("grant", 64'(req_ready), 64'(1) << id);
        tick();
        check("lo_valid", 64'(rsp_valid), 64'd0);
        check("lo_busy", 64'(busy), 64'd1);
        check("lo_ready", 64'(req_ready), 64'd0);
        tick();
        check("hi_valid", 64'(rsp_valid), 64'd0);
        tick();
        check("resp_valid", 64'(rsp_valid), 64'd1);
        check("resp_id", 64'(rsp_id), 64'(id));
        check("resp_sum", 64'(rsp_sum), 64'(exp_sum[id]));
        check("resp_ovf", 64'(rsp_ovf), 64'(exp_ovf[id]));
        for (int h = 0; h < hold; h++) begin
            tick();
            check("stall_valid", 64'(rsp_valid), 64'd1);
            check("stall_sum", 64'(rsp_sum), 64'(exp_sum[id]));
            check("stall_id", 64'(rsp_id), 64'(id));
            check("stall_ready", 64'(req_ready), 64'd0);
            check("stall_busy", 64'(busy), 64'd1);
            check("stall_count", 64'(op_count), 64'(exp_cnt));
        end
        rsp_ready = 1'b1;
        tick();
        exp_cnt = exp_cnt + 16'd1;
        check("count", 64'(op_count), 64'(exp_cnt));
        check("idle_valid", 64'(rsp_valid), 64'd0);
        check("hold_sum", 64'(rsp_sum), 64'(exp_sum[id]));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_cnt     = '0;
        rst_n       = 1'b0;
        req_valid   = '0;
        req_a       = '0;
        req_b       = '0;
        req_cin     = '0;
        rsp_ready   = 1'b0;
        #3;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(rsp_valid), 64'd0);
        check("rst_count", 64'(op_count), 64'd0);
        check("rst_sum", 64'(rsp_sum), 64'd0);
        check("rst_id", 64'(rsp_id), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        set_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33'h1_0000_0000, 1'b0);
        set_op(1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 33'h0_8000_0000, 1'b1);
        set_op(2, 32'h0000_FFFF, 32'h0000_0000, 1'b1, 33'h0_0001_0000, 1'b0);
        set_op(3, 32'h8000_0000, 32'h8000_0000, 1'b1, 33'h1_0000_0001, 1'b1);

        // Single requests: carry across halves, then the two overflow cases.
        req_valid = 4'b0001;
        run_op(0, 0);
        req_valid = 4'b0010;
        run_op(1, 0);
        req_valid = 4'b0100;
        run_op(2, 0);

        // Two contenders alternate.
        req_valid = 4'b0101;
        run_op(0, 0);
        run_op(2, 0);
        run_op(0, 0);
        run_op(2, 0);

        // All contend after 2 was last granted.
        req_valid = 4'b1111;
        run_op(3, 0);
        run_op(0, 0);
        run_op(1, 0);
        run_op(2, 0);

        // Backpressure on 3, then 0 is granted right after release.
        run_op(3, 5);
        run_op(0, 0);

        // Reset while requester 1 is in its high pass.
        #1;
        check("mr_grant", 64'(req_ready), 64'b0010);
        tick();
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        exp_cnt = '0;
        check("mr_busy", 64'(busy), 64'd0);
        check("mr_valid", 64'(rsp_valid), 64'd0);
        check("mr_count", 64'(op_count), 64'd0);
        check("mr_sum", 64'(rsp_sum), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("mr_no_rsp", 64'(rsp_valid), 64'd0);
        run_op(0, 0);

        // Back-to-back zero adds on one requester keep the count stepping by one.
        req_valid = 4'b0001;
        set_op(0, 32'h0, 32'h0, 1'b0, 33'h0, 1'b0);
        for (int n = 0; n < 12; n++) run_op(0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/adder_share_ctrl.md
Name: adder_share_ctrl

Overview:
Round-robin scheduler that time-shares one 16-bit ripple-carry adder datapath among NUM_REQ requesters. Each request is a 32-bit add with carry-in. The block runs it as two chained 16-bit passes through the single shared adder: low half first, then high half using the carry from the low pass. It returns a 33-bit result tagged with the requester ID. The block sits between requesting units and the adder and is the only instantiator of that adder.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of requester ID; must equal clog2(NUM_REQ)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset; asynchronous, active-low
req_valid  in  NUM_REQ  bit i: requester i presents an operation
req_ready  out  NUM_REQ  bit i: requester i operation accepted this cycle (one-hot or zero)
req_a  in  NUM_REQ*32  operand A; requester i on bits [32*i+31:32*i]
req_b  in  NUM_REQ*32  operand B, same packing
req_cin  in  NUM_REQ  carry-in per requester
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_id  out  ID_W  requester index of current result
rsp_sum  out  33  {carry_out, sum[31:0]}
rsp_ovf  out  1  signed overflow of the 32-bit add
busy  out  1  high in any state other than IDLE
op_count  out  16  completed responses; wraps 0xFFFF -> 0x0000

Behaviour:
- Reset (async assert, sync release): state = IDLE, rr_ptr = NUM_REQ-1, all captured operands 0; rsp_valid = 0, rsp_id = 0, rsp_sum = 0, rsp_ovf = 0, busy = 0, op_count = 0, req_ready = 0.
- FSM states: IDLE -> LO -> HI -> RESP -> IDLE.
- IDLE: the grant is computed combinationally. Search starts at index rr_ptr+1 (mod NUM_REQ) and picks the first i with req_valid[i]=1. req_ready[i] = 1 for the granted i only; all other bits are 0.
- IDLE with no req_valid bit set: req_ready = 0; stay in IDLE.
- IDLE handshake edge (req_valid[i] and req_ready[i]): capture A, B, cin and id = i; rr_ptr <= i; go to LO.
- LO: adder inputs are A[15:0], B[15:0], cin. At the edge, capture sum_lo and c_mid; go to HI.
- HI: adder inputs are A[31:16], B[31:16], c_mid. At the edge, capture sum_hi and cout; go to RESP.
- RESP: rsp_valid = 1, rsp_sum = {cout, sum_hi, sum_lo}, rsp_ovf = (A[31]==B[31]) && (sum_hi[15]!=A[31]), rsp_id = id.
- rsp_* outputs stay stable while rsp_ready = 0.
- RESP edge with rsp_ready = 1: op_count <= op_count+1; go to IDLE.
- rsp_valid outside RESP = 0. rsp_sum, rsp_id and rsp_ovf hold their last values.
- req_ready = 0 in LO, HI and RESP. No request is accepted until the FSM returns to IDLE.
- Latency: rsp_valid rises 3 cycles after the accept edge. Minimum issue interval is 4 cycles per operation.
- The adder is combinational and settles within one cycle. Only one adder instance exists; no pass bypasses it.
- Requester obligation: req_* inputs may change freely while req_ready[i] = 0. The captured copy is what gets computed.
- Simultaneous requests: strict round-robin. The most recently granted requester has lowest priority at the next grant.
- A requester deasserting req_valid before grant is not an error; it simply is not granted.
- rst_n asserted mid-operation (LO, HI or RESP): the in-flight operation is dropped with no response, and all state returns to reset values immediately.
- Width rule: the 33-bit result equals the unsigned A+B+cin exactly. Carry out of bit 15 feeds only the HI pass.

Test Plan:
- Carry across halves: requester 0, A=0xFFFFFFFF, B=0x00000001, cin=0 -> rsp_sum=0x1_00000000, rsp_ovf=0, rsp_id=0, rsp_valid exactly 3 cycles after accept.
- Signed overflow: A=0x7FFFFFFF, B=1, cin=0 -> rsp_sum=0x0_80000000, rsp_ovf=1. Also A=0x0000FFFF, B=0, cin=1 -> rsp_sum=0x0_00010000, rsp_ovf=0.
- Round-robin: req_valid=0b0101 held constant, each response consumed immediately -> grant order 0,2,0,2, with req_ready one-hot each IDLE cycle. Then req_valid=0b1111 after granting 2 -> next grants 3,0,1,2.
- Backpressure: rsp_ready=0 for 5 cycles in RESP, with all req_valid=1 -> rsp_* outputs stable, req_ready=0, busy=1. On rsp_ready=1, op_count increments by exactly 1 and the next grant occurs in the following IDLE cycle.
- Reset mid-op: assert rst_n=0 during HI -> busy, rsp_valid, op_count and rsp_sum go to 0 without waiting for a clock edge; no response appears after release. The first post-reset grant goes to requester 0 when all requesters are valid.
- Counter wrap: complete 65536 operations (A=B=0) -> op_count reads 0x0000 after the last response.
